bus_to_stream_bridge: RTL and testbench



---
 rtl/bus_to_stream_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_bus_to_stream_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_to_stream_bridge.sv
// Bus-to-stream bridge: the CPU pushes samples into a FIFO through a small register map.
// A one-entry output stage presents them on a valid/ready stream, with low-water irq and underrun accounting.
module bus_to_stream_bridge #(
    parameter int DATA_SIZE = 24,
    parameter int DEPTH     = 16,
    parameter int LEVEL_W   = $clog2(DEPTH) + 1,
    parameter int LOW_WATER = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          read_data,
    output logic                 stream_valid,
    output logic [DATA_SIZE-1:0] stream_data,
    input  logic                 stream_ready,
    output logic                 irq
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]   level_q, level_d, thresh_q, thresh_d;
    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [31:0]          read_data_q, read_data_d;
    logic                 enable_q, enable_d, irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;
    logic [15:0]          unf_cnt_q, unf_cnt_d;

    logic push_req_s, ctrl_wr_s, thresh_wr_s, flush_s, clear_s;
    logic full_s, empty_s, do_push_s, do_load_s, underrun_s;
    logic [31:0] status_s;
    logic unused_s;

    assign unused_s = ^writedata;

    // Decode bus strobes and decide what the FIFO does this cycle.
    always_comb begin
        push_req_s  = chipselect & write & (address == 2'd0);
        ctrl_wr_s   = chipselect & write & (address == 2'd2);
        thresh_wr_s = chipselect & write & (address == 2'd3);
        flush_s     = ctrl_wr_s & writedata[2];
        clear_s     = ctrl_wr_s & writedata[3];
        full_s      = (level_q == LEVEL_W'(DEPTH));
        empty_s     = (level_q == '0);
        do_push_s   = push_req_s & ~full_s & ~flush_s;
        do_load_s   = enable_q & ~empty_s & (~valid_q | stream_ready) & ~flush_s;
        underrun_s  = enable_q & stream_ready & ~valid_q;
    end

    // Status word assembled from pre-edge state so a same-cycle write never shows through.
    always_comb begin
        status_s              = 32'd0;
        status_s[LEVEL_W-1:0] = level_q;
        status_s[8]           = valid_q;
        status_s[9]           = full_s;
        status_s[10]          = empty_s;
        status_s[11]          = ovf_q;
        status_s[12]          = unf_q;
        status_s[31:16]       = unf_cnt_q;
    end

    // Next-state logic for FIFO, output stage, registers and accounting.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        valid_d     = valid_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        thresh_d    = thresh_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        unf_cnt_d   = unf_cnt_q;

        if (do_push_s) begin
            mem_d[wr_ptr_q] = writedata[DATA_SIZE-1:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_load_s) begin
            valid_d  = 1'b1;
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (valid_q & stream_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (flush_s) begin
            level_d  = '0;
            valid_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            level_d = level_q + LEVEL_W'(do_push_s) - LEVEL_W'(do_load_s);
        end

        if (ctrl_wr_s) begin
            enable_d = writedata[0];
            irq_en_d = writedata[1];
        end else begin
            enable_d = enable_q;
        end

        if (thresh_wr_s) begin
            thresh_d = writedata[LEVEL_W-1:0];
        end else begin
            thresh_d = thresh_q;
        end

        // A clear request wins over events flagged in the same cycle.
        if (clear_s) begin
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            unf_cnt_d = 16'd0;
        end else begin
            if (push_req_s & full_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (underrun_s) begin
                unf_d = 1'b1;
                if (unf_cnt_q != 16'hFFFF) begin
                    unf_cnt_d = unf_cnt_q + 16'd1;
                end else begin
                    unf_cnt_d = unf_cnt_q;
                end
            end else begin
                unf_d = unf_q;
            end
        end

        if (chipselect & read) begin
            case (address)
                2'd0:    read_data_d = 32'd0;
                2'd1:    read_data_d = status_s;
                2'd2:    read_data_d = {30'd0, irq_en_q, enable_q};
                2'd3:    read_data_d = {{(32-LEVEL_W){1'b0}}, thresh_q};
                default: read_data_d = 32'd0;
            endcase
        end else begin
            read_data_d = read_data_q;
        end

        irq_d = irq_en_q & enable_q & (level_q <= thresh_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            read_data_q <= 32'd0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            thresh_q    <= LEVEL_W'(LOW_WATER);
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            unf_cnt_q   <= 16'd0;
            irq_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            thresh_q    <= thresh_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            unf_cnt_q   <= unf_cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign read_data    = read_data_q;
    assign stream_valid = valid_q;
    assign stream_data  = data_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_bus_to_stream_bridge.sv
// Scoreboard bench for bus_to_stream_bridge: expected stream words and register reads are queued
// at issue time and checked by a monitor on the falling edge.
module tb_bus_to_stream_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, read, write, stream_ready;
    logic [1:0]  address;
    logic [31:0] writedata, read_data;
    logic        stream_valid, irq;
    logic [23:0] stream_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb_q[$];
    logic [31:0] rd_exp_q[$];
    logic [31:0] rd_mask_q[$];
    string       rd_name_q[$];
    logic        rd_issue = 1'b0;

    bus_to_stream_bridge #(.DATA_SIZE(24), .DEPTH(16), .LOW_WATER(4)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .read_data(read_data),
        .stream_valid(stream_valid), .stream_data(stream_data),
        .stream_ready(stream_ready), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: remembers which edges captured a read, then checks outputs mid-cycle.
    always @(posedge clk) rd_issue <= chipselect & read & reset;

    always @(negedge clk) begin
        if (rd_issue) begin
            if (rd_exp_q.size() == 0) begin
                check("read_unexpected", read_data, 32'hDEAD_BEEF);
            end else begin
                check(rd_name_q.pop_front(), read_data & rd_mask_q.pop_front(), rd_exp_q.pop_front());
            end
        end
        if (reset && stream_valid && stream_ready) begin
            if (sb_q.size() == 0) begin
                check("stream_unexpected", {8'd0, stream_data}, 32'hDEAD_BEEF);
            end else begin
                check("stream_data", {8'd0, stream_data}, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bw(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic br(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m, input string n);
        rd_exp_q.push_back(e & m); rd_mask_q.push_back(m); rd_name_q.push_back(n);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        sb_q.push_back(d & 32'h00FF_FFFF);
        bw(2'd0, d);
    endtask

    initial begin
        reset = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0; stream_ready = 1'b0;
        repeat (3) tick();
        check("rst_read_data", read_data, 32'd0);
        check("rst_valid", {31'd0, stream_valid}, 32'd0);
        check("rst_data", {8'd0, stream_data}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        tick();
        br(2'd1, 32'h0000_0400, 32'hFFFF_FFFF, "rst_status");
        br(2'd2, 32'd0, 32'hFFFF_FFFF, "rst_ctrl");
        br(2'd3, 32'd4, 32'hFFFF_FFFF, "rst_thresh");
        br(2'd0, 32'd0, 32'hFFFF_FFFF, "addr0_read");

        // Streaming with latency 1 and underrun counting
        stream_ready = 1'b1;
        bw(2'd2, 32'h1);
        push(32'h1);
        push(32'h2);
        check("first_latency_valid", {31'd0, stream_valid}, 32'd1);
        check("first_latency_data", {8'd0, stream_data}, 32'h1);
        push(32'h3);
        check("second_data", {8'd0, stream_data}, 32'h2);
        br(2'd1, 32'h0002_1101, 32'hFFFF_FFFF, "status_underrun");
        check("third_data", {8'd0, stream_data}, 32'h3);
        repeat (3) tick();

        // Overflow while disabled, then drain 16 words
        stream_ready = 1'b0;
        bw(2'd2, 32'h8);
        br(2'd1, 32'h0000_0400, 32'hFFFF_FFFF, "status_cleared");
        for (int i = 0; i < 16; i++) push(32'h100 + i);
        bw(2'd0, 32'h1FF);
        br(2'd1, 32'h0000_0A10, 32'hFFFF_FFFF, "status_full_ovf");
        stream_ready = 1'b1;
        bw(2'd2, 32'h1);
        repeat (20) tick();
        stream_ready = 1'b0;
        check("drain16_sb_empty", sb_q.size(), 32'd0);
        br(2'd1, 32'h0000_1C00, 32'h0000_FFFF, "status_drained");
        bw(2'd2, 32'h8);
        br(2'd1, 32'h0000_0400, 32'hFFFF_FFFF, "status_cleared2");

        // Backpressure holds the output stage stable
        bw(2'd2, 32'h1);
        for (int i = 0; i < 4; i++) push(32'h200 + i);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, stream_valid}, 32'd1);
            check("bp_data", {8'd0, stream_data}, 32'h200);
        end
        stream_ready = 1'b1;
        repeat (8) tick();
        stream_ready = 1'b0;
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Push and pop together at level 8, then wrap the pointers
        bw(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) push(32'h300 + i);
        bw(2'd2, 32'h1);
        tick();
        stream_ready = 1'b1;
        push(32'h309);
        stream_ready = 1'b0;
        br(2'd1, 32'h0000_0108, 32'h0000_07FF, "status_level8");
        stream_ready = 1'b1;
        for (int i = 0; i < 40; i++) push(32'h400 + i);
        repeat (20) tick();
        stream_ready = 1'b0;
        check("wrap_sb_empty", sb_q.size(), 32'd0);

        // Low-water interrupt rise and fall
        bw(2'd2, 32'h0);
        bw(2'd3, 32'd4);
        for (int i = 0; i < 6; i++) push(32'h500 + i);
        bw(2'd2, 32'h3);
        tick();
        tick();
        check("irq_above", {31'd0, irq}, 32'd0);
        stream_ready = 1'b1;
        tick();
        stream_ready = 1'b0;
        check("irq_lag", {31'd0, irq}, 32'd0);
        tick();
        check("irq_rise", {31'd0, irq}, 32'd1);
        push(32'h506);
        check("irq_hold", {31'd0, irq}, 32'd1);
        tick();
        check("irq_fall", {31'd0, irq}, 32'd0);
        br(2'd2, 32'd3, 32'hFFFF_FFFF, "ctrl_read");

        // Flush at level 10 with a word waiting in the output stage
        for (int i = 0; i < 5; i++) push(32'h507 + i);
        br(2'd1, 32'h0000_010A, 32'h0000_07FF, "status_level10");
        bw(2'd2, 32'h7);
        sb_q.delete();
        check("flush_valid", {31'd0, stream_valid}, 32'd0);
        br(2'd1, 32'h0000_0400, 32'h0000_07FF, "status_flushed");
        push(32'h600);
        stream_ready = 1'b1;
        repeat (4) tick();
        check("flush_sb_empty", sb_q.size(), 32'd0);
        bw(2'd2, 32'h8);
        br(2'd1, 32'h0000_0400, 32'hFFFF_FFFF, "status_clear_final");

        // Read and write the threshold together: the read sees the old value
        rd_exp_q.push_back(32'd4); rd_mask_q.push_back(32'hFFFF_FFFF); rd_name_q.push_back("rw_same_reg");
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'd7;
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        br(2'd3, 32'd7, 32'hFFFF_FFFF, "thresh_new");

        repeat (3) tick();
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);
        check("sb_final_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
